// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between the in-order
// pipeline writeback stage (pipe) and the long-latency unit (lu), and keeps a
// scoreboard of registers with an outstanding lu result for decode RAW stalls.
//
// Optional build macro RF_WB_STARVE_GUARD_EN adds a starvation guard: after
// STARVE_MAX consecutive blocked cycles the lu is granted for one cycle while
// pipe_stall_o freezes the writeback stage. Without the macro the pipe always
// wins and pipe_stall_o is tied to 0.
//
// Handshake: the lu presents lu_valid_i with addr/data held stable; a transfer
// happens in any cycle where lu_valid_i and lu_ready_o are both 1. The pipe has
// no ready; its only backpressure is pipe_stall_o.
module rf_wb_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we_i,
  input  logic [ADDR_W-1:0] pipe_waddr_i,
  input  logic [DATA_W-1:0] pipe_wdata_i,
  input  logic              lu_issue_i,
  input  logic [ADDR_W-1:0] lu_issue_addr_i,
  input  logic              lu_valid_i,
  input  logic [ADDR_W-1:0] lu_addr_i,
  input  logic [DATA_W-1:0] lu_data_i,
  output logic              lu_ready_o,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic              raw_stall_o,
  output logic              pipe_stall_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o
);

  localparam int NREG = 1 << ADDR_W;

  // Out-of-range STARVE_MAX shows up as this marker scope in the hierarchy.
  if (STARVE_MAX < 2 || STARVE_MAX > 255) begin : g_bad_starve_max
  end

  logic              pipe_req;
  logic              force_grant;
  logic              lu_ready;
  logic              lu_xfer;

  logic [NREG-1:0]   busy_q, busy_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  // Writes to r0 are discarded, so they never compete for the port.
  assign pipe_req = pipe_we_i && (pipe_waddr_i != '0);

`ifdef RF_WB_STARVE_GUARD_EN
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(STARVE_MAX - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  assign force_grant = (state_q == ST_FORCE);

  // Starvation tracking: cnt counts consecutive blocked cycles including the
  // current one; once it reaches STARVE_MAX-1 the next cycle is FORCE, which
  // makes FORCE the STARVE_MAX-th cycle of the lu's wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (lu_valid_i && !lu_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = (cnt_d == CNT_LAST) ? ST_FORCE : ST_WAIT;
        end else begin
          cnt_d   = 8'd0;
          state_d = ST_IDLE;
        end
      end
      ST_FORCE: begin
        cnt_d   = 8'd0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Starvation FSM state and counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign force_grant = 1'b0;
`endif

  assign lu_ready     = lu_valid_i && (force_grant || !pipe_req);
  assign lu_xfer      = lu_valid_i && lu_ready;
  assign lu_ready_o   = rst && lu_ready;
  assign pipe_stall_o = rst && force_grant;
  assign raw_stall_o  = rst && (busy_q[rs_addr_i] || busy_q[rt_addr_i]);

  // Port winner selection; addr/data hold when nothing is written.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_req && !force_grant) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_waddr_i;
      rf_wdata_d = pipe_wdata_i;
    end else if (lu_xfer && (lu_addr_i != '0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = lu_addr_i;
      rf_wdata_d = lu_data_i;
    end
  end

  // Scoreboard update: clear on lu transfer, then set on issue so a
  // same-register set wins; r0 is never tracked.
  always_comb begin
    busy_d = busy_q;
    if (lu_xfer) begin
      busy_d[lu_addr_i] = 1'b0;
    end
    if (lu_issue_i && (lu_issue_addr_i != '0)) begin
      busy_d[lu_issue_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Registered write port and scoreboard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single general-purpose register write port between two writers: the in-order pipeline writeback stage (pipe) and the long-latency unit (lu; divider/multiplier result path).
- Keeps a 32-entry scoreboard of registers with an outstanding lu result and raises a RAW stall to decode.
- Sits between the writeback stage, the long-latency unit and the register file write port.
- Optional starvation guard briefly freezes the pipeline so a waiting lu result can write.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- STARVE_MAX, 8, consecutive lu-blocked cycles before a forced lu grant (guard only); legal range 2..255

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- pipe_we_i  in  1  pipeline writeback request; no backpressure except pipe_stall_o
- pipe_waddr_i  in  ADDR_W  pipeline destination register
- pipe_wdata_i  in  DATA_W  pipeline write data
- lu_issue_i  in  1  lu operation issued this cycle; reserves its destination register
- lu_issue_addr_i  in  ADDR_W  destination register of the issued lu operation
- lu_valid_i  in  1  lu result available
- lu_addr_i  in  ADDR_W  lu result destination register
- lu_data_i  in  DATA_W  lu result data
- lu_ready_o  out  1  lu result accepted this cycle (combinational)
- rs_addr_i  in  ADDR_W  decode rs read address
- rt_addr_i  in  ADDR_W  decode rt read address
- raw_stall_o  out  1  decode must stall: rs or rt is pending in the scoreboard
- pipe_stall_o  out  1  pipeline must hold its WB stage this cycle (guard)
- rf_we_o  out  1  register file write enable (registered)
- rf_waddr_o  out  ADDR_W  register file write address (registered)
- rf_wdata_o  out  DATA_W  register file write data (registered)

Behaviour:
- Reset (async, rst=0):
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - Scoreboard busy[31:0]=0; FSM=IDLE; starve counter=0.
  - lu_ready_o, raw_stall_o and pipe_stall_o evaluate to 0 while in reset.
  - A reset mid-operation drops every pending reservation and any in-flight grant.
- Arbitration, per cycle:
  - pipe_req = pipe_we_i and pipe_waddr_i != 0.
  - Normal case: pipe_req wins. lu_ready_o = lu_valid_i and not pipe_req.
  - FORCE case: lu_ready_o = lu_valid_i; the pipe is not granted.
  - A transfer occurs when lu_valid_i and lu_ready_o are both 1.
- Output register:
  - Latency is 1 cycle: the winner's addr/data appear on rf_* at the next rising edge, with rf_we_o=1.
  - No winner: rf_we_o=0; rf_waddr_o and rf_wdata_o hold their previous values.
  - An lu transfer to r0 completes the handshake but gives rf_we_o=0.
- Scoreboard:
  - Set: busy[lu_issue_addr_i] is set at the clock edge when lu_issue_i=1 and lu_issue_addr_i != 0.
  - Clear: busy[lu_addr_i] is cleared on an lu transfer.
  - Set and clear to the same register in the same cycle: set wins.
  - busy[0] is never set.
  - raw_stall_o = busy[rs_addr_i] or busy[rt_addr_i]. It is combinational, and rs/rt = 0 never stall.
  - Once busy clears, the register file write-port bypass covers the following cycle; no extra stall is added.
- A pipe write to a busy register is accepted and does not change the scoreboard (ordering is decode's responsibility).
- Starvation FSM, guard built in:
  - IDLE -> WAIT when lu_valid_i and not lu_ready_o; counter=1.
  - WAIT, while blocked: counter increments each cycle.
  - WAIT -> FORCE when counter = STARVE_MAX-1 and still blocked.
  - WAIT -> IDLE if lu_valid_i=0 or a transfer occurs; counter=0.
  - FORCE, exactly one cycle: pipe_stall_o=1 (combinational from state) and the lu is granted. Then -> IDLE, counter=0.
  - While pipe_stall_o=1, the pipeline holds pipe_we_i, pipe_waddr_i and pipe_wdata_i unchanged into the next cycle. That request is then serviced normally.
- FORCE entered with lu_valid_i already 0: not possible by construction. If it is seen on a faulty input, FORCE still lasts 1 cycle with no transfer.

Optional Feature:
- Macro: RF_WB_STARVE_GUARD_EN.
- Defined: the starvation FSM, counter and pipe_stall_o are built in as specified above.
- Undefined: no FSM and no counter; pipe_stall_o is tied to 0. The pipe always wins, and the lu waits for a cycle with no pipe_req.

Test Plan:
- Reset: rst=0 mid-stream with busy[5]=1 and rf_we_o=1 -> all outputs 0 immediately; after release, raw_stall_o=0 for rs=5.
- Contention: pipe_we_i=1 (r3, 0xAAAA0001) and lu_valid_i=1 (r4, 0x55550002) in the same cycle -> lu_ready_o=0; next edge rf_we_o=1, rf_waddr_o=3. The following cycle, with pipe idle -> lu_ready_o=1 and r4 is written 1 cycle later.
- Scoreboard: lu_issue_i to r7, then rs_addr_i=7 -> raw_stall_o=1 until the lu transfer to r7. The cycle after that, raw_stall_o=0 and rf_we_o=1 with rf_waddr_o=7.
- Same-cycle set/clear: an lu transfer for r9 and lu_issue_i for r9 in one cycle -> busy[9] stays 1.
- r0: lu transfer to r0 -> lu_ready_o=1 and rf_we_o=0; pipe_we_i to r0 does not block lu_ready_o.
- Guard (EN): pipe_we_i=1 continuously with lu_valid_i=1 and STARVE_MAX=8 -> pipe_stall_o=1 in exactly the 8th blocked cycle, lu granted in that cycle. Without the EN macro: the lu stays blocked and pipe_stall_o=0 throughout.
